// File: rtl/uart_apb_regfile.sv
// APB register file for the UART: TX data/config/control, RX FIFO, sticky status, slave errors.
// Optional interrupt (IER register and irq output) enabled by defining UART_REG_IRQ_EN.
module uart_apb_regfile #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int RX_DEPTH = 4
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [DATA_W-1:0] tx_data,
    output logic              start_tx,
    output logic [4:0]        cfg,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_parity_err,
    output logic              irq
);

    localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int LVL_W = $clog2(RX_DEPTH) + 1;

    localparam logic [ADDR_W-1:0] A_TX   = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_RX   = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_CFG  = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] A_STT  = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] A_IER  = ADDR_W'(8'h14);
    localparam logic [ADDR_W-1:0] A_LVL  = ADDR_W'(8'h18);

    logic              setup, access;
    logic              sel_tx, sel_rx, sel_cfg, sel_ctrl, sel_stt, sel_ier, sel_lvl;
    logic              setup_err;
    logic [31:0]       rd_val;
    logic              acc_ok, pop_ok;
    logic              wr_commit, pop, push_ok;
    logic [31:0]       clr;

    logic [DATA_W-1:0] mem [RX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level, level_n;
    logic              fifo_empty, fifo_full;

    logic              txdone_q, perr_q, ovr_q;
    logic              txdone_n, perr_n, ovr_n;
    logic [3:0]        ier_rd;
    logic              unused_pwdata;

    assign pready        = 1'b1;
    assign unused_pwdata = ^pwdata;

    assign setup  = psel & ~penable;
    assign access = psel & penable;

    assign sel_tx   = (paddr == A_TX);
    assign sel_rx   = (paddr == A_RX);
    assign sel_cfg  = (paddr == A_CFG);
    assign sel_ctrl = (paddr == A_CTRL);
    assign sel_stt  = (paddr == A_STT);
    assign sel_ier  = (paddr == A_IER);
    assign sel_lvl  = (paddr == A_LVL);

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LVL_W'(RX_DEPTH));

    // Misaligned addresses never match a decode, so they fall out as unmapped.
    always_comb begin
        setup_err = 1'b0;
        if (|paddr[1:0])
            setup_err = 1'b1;
        if (!(sel_tx | sel_rx | sel_cfg | sel_ctrl | sel_stt | sel_ier | sel_lvl))
            setup_err = 1'b1;
        if (pwrite & (sel_rx | sel_lvl | (sel_stt & (pwdata[1] | pwdata[4]))))
            setup_err = 1'b1;
        if (pwrite & tx_busy & (sel_tx | sel_ctrl))
            setup_err = 1'b1;
    end

    always_comb begin
        rd_val = '0;
        if (sel_tx)
            rd_val = 32'(tx_data);
        else if (sel_rx && !fifo_empty)
            rd_val = 32'(mem[rd_ptr]);
        else if (sel_cfg)
            rd_val = 32'(cfg);
        else if (sel_stt)
            rd_val = {27'b0, tx_busy, ovr_q, perr_q, ~fifo_empty, txdone_q};
        else if (sel_ier)
            rd_val = 32'(ier_rd);
        else if (sel_lvl)
            rd_val = 32'(level);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            prdata  <= '0;
            pslverr <= 1'b0;
            acc_ok  <= 1'b0;
            pop_ok  <= 1'b0;
        end else if (setup) begin
            prdata  <= setup_err ? 32'b0 : rd_val;
            pslverr <= setup_err;
            acc_ok  <= ~setup_err;
            pop_ok  <= ~setup_err & ~pwrite & sel_rx & ~fifo_empty;
        end else begin
            pslverr <= 1'b0;
            acc_ok  <= 1'b0;
            pop_ok  <= 1'b0;
        end
    end

    assign wr_commit = access & acc_ok & pwrite;
    assign pop       = access & pop_ok;
    assign clr       = (wr_commit & sel_stt) ? pwdata : 32'b0;
    // A full FIFO still accepts a character when the head leaves in the same cycle.
    assign push_ok   = rx_valid & (~fifo_full | pop);

    always_comb begin
        level_n = level;
        case ({push_ok, pop})
            2'b10:   level_n = level + 1'b1;
            2'b01:   level_n = level - 1'b1;
            default: level_n = level;
        endcase
        txdone_n = tx_done | (txdone_q & ~clr[0]);
        perr_n   = (rx_valid & rx_parity_err) | (perr_q & ~clr[2]);
        ovr_n    = (rx_valid & fifo_full & ~pop) | (ovr_q & ~clr[3]);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            tx_data  <= '0;
            cfg      <= '0;
            start_tx <= 1'b0;
            txdone_q <= 1'b0;
            perr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
        end else begin
            if (wr_commit & sel_tx)
                tx_data <= pwdata[DATA_W-1:0];
            if (wr_commit & sel_cfg)
                cfg <= pwdata[4:0];
            start_tx <= wr_commit & sel_ctrl & pwdata[0];
            txdone_q <= txdone_n;
            perr_q   <= perr_n;
            ovr_q    <= ovr_n;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level_n;
        end
    end

    always_ff @(posedge pclk) begin
        if (push_ok)
            mem[wr_ptr] <= rx_data;
    end

`ifdef UART_REG_IRQ_EN
    logic [3:0] ier, ier_n;

    assign ier_rd = ier;
    assign ier_n  = (wr_commit & sel_ier) ? pwdata[3:0] : ier;

    // Built from next-state status so irq follows its cause by one cycle.
    always_ff @(posedge pclk) begin
        if (preset) begin
            ier <= '0;
            irq <= 1'b0;
        end else begin
            ier <= ier_n;
            irq <= |({ovr_n, perr_n, (level_n != '0), txdone_n} & ier_n);
        end
    end
`else
    assign ier_rd = 4'b0;
    assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_apb_regfile.sv
// Directed bench for uart_apb_regfile: table-driven register accesses plus FIFO/status/irq sequences.
module tb_uart_apb_regfile;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel, penable, pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  tx_data;
    logic        start_tx;
    logic [4:0]  cfg;
    logic        tx_busy, tx_done, rx_valid, rx_parity_err;
    logic [7:0]  rx_data;
    logic        irq;

    int total = 0;
    int bad   = 0;
    logic start_at_access;

`ifdef UART_REG_IRQ_EN
    localparam logic [31:0] IER_RB = 32'h4;
    localparam logic        IRQ_ON = 1'b1;
`else
    localparam logic [31:0] IER_RB = 32'h0;
    localparam logic        IRQ_ON = 1'b0;
`endif

    always #5 pclk = ~pclk;

    uart_apb_regfile #(.ADDR_W(5), .DATA_W(8), .RX_DEPTH(4)) dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .tx_data(tx_data), .start_tx(start_tx), .cfg(cfg), .tx_busy(tx_busy), .tx_done(tx_done),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_parity_err(rx_parity_err), .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                       input logic acc_rxv, input logic [7:0] acc_rxd, input logic acc_txd,
                       output logic [31:0] rd, output logic err);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge pclk); #1;
        penable = 1'b1;
        rx_valid = acc_rxv; rx_data = acc_rxd; tx_done = acc_txd;
        rd = prdata; err = pslverr; start_at_access = start_tx;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rx_valid = 1'b0; tx_done = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        err;
        apb(1'b0, addr, 32'h0, 1'b0, 8'h0, 1'b0, rd, err);
        chk({name, "_data"}, rd, exp);
        chk({name, "_err"}, 32'(err), 32'h0);
    endtask

    task automatic wr_chk(input string name, input logic [4:0] addr, input logic [31:0] wd,
                          input logic exp_err);
        logic [31:0] rd;
        logic        err;
        apb(1'b1, addr, wd, 1'b0, 8'h0, 1'b0, rd, err);
        chk({name, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic pulse_rx(input logic [7:0] d, input logic perr);
        @(posedge pclk); #1;
        rx_valid = 1'b1; rx_data = d; rx_parity_err = perr;
        @(posedge pclk); #1;
        rx_valid = 1'b0; rx_parity_err = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd;
        logic        err;

        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        tx_busy = 1'b0; tx_done = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_parity_err = 1'b0;
        start_at_access = 1'b0;

        repeat (3) @(posedge pclk);
        #1;
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pslverr", 32'(pslverr), 32'h0);
        chk("rst_start_tx", 32'(start_tx), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_cfg", 32'(cfg), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("pready", 32'(pready), 32'h1);
        preset = 1'b0;
        @(posedge pclk); #1;
        chk("post_rst_prdata", prdata, 32'h0);

        vecs.push_back('{1'b0, 5'h00, 32'h0, 32'h0, 1'b0, "rst_tx_data_rd"});
        vecs.push_back('{1'b0, 5'h04, 32'h0, 32'h0, 1'b0, "rst_rx_data_rd"});
        vecs.push_back('{1'b0, 5'h08, 32'h0, 32'h0, 1'b0, "rst_cfg_rd"});
        vecs.push_back('{1'b0, 5'h0C, 32'h0, 32'h0, 1'b0, "rst_ctrl_rd"});
        vecs.push_back('{1'b0, 5'h10, 32'h0, 32'h0, 1'b0, "rst_stt_rd"});
        vecs.push_back('{1'b0, 5'h14, 32'h0, 32'h0, 1'b0, "rst_ier_rd"});
        vecs.push_back('{1'b0, 5'h18, 32'h0, 32'h0, 1'b0, "rst_lvl_rd"});
        vecs.push_back('{1'b1, 5'h08, 32'h1B, 32'h0, 1'b0, "cfg_wr"});
        vecs.push_back('{1'b0, 5'h08, 32'h0, 32'h1B, 1'b0, "cfg_rd"});
        vecs.push_back('{1'b1, 5'h00, 32'h5A, 32'h0, 1'b0, "tx_wr"});
        vecs.push_back('{1'b0, 5'h00, 32'h0, 32'h5A, 1'b0, "tx_rd"});
        vecs.push_back('{1'b1, 5'h1C, 32'hFF, 32'h0, 1'b1, "unmapped_wr"});
        vecs.push_back('{1'b1, 5'h02, 32'hFF, 32'h0, 1'b1, "misaligned_wr"});
        vecs.push_back('{1'b1, 5'h0A, 32'h03, 32'h0, 1'b1, "misaligned_cfg_wr"});
        vecs.push_back('{1'b0, 5'h08, 32'h0, 32'h1B, 1'b0, "cfg_unchanged_rd"});
        vecs.push_back('{1'b0, 5'h00, 32'h0, 32'h5A, 1'b0, "tx_unchanged_rd"});
        vecs.push_back('{1'b0, 5'h1C, 32'h0, 32'h0, 1'b1, "unmapped_rd"});
        vecs.push_back('{1'b0, 5'h01, 32'h0, 32'h0, 1'b1, "misaligned_rd"});
        vecs.push_back('{1'b1, 5'h04, 32'h1, 32'h0, 1'b1, "rx_data_wr"});
        vecs.push_back('{1'b1, 5'h18, 32'h1, 32'h0, 1'b1, "lvl_wr"});
        vecs.push_back('{1'b1, 5'h10, 32'h2, 32'h0, 1'b1, "stt_bit1_wr"});
        vecs.push_back('{1'b1, 5'h10, 32'h10, 32'h0, 1'b1, "stt_bit4_wr"});
        vecs.push_back('{1'b1, 5'h10, 32'h1, 32'h0, 1'b0, "stt_w1c_wr"});
        vecs.push_back('{1'b1, 5'h14, 32'h4, 32'h0, 1'b0, "ier_wr"});
        vecs.push_back('{1'b0, 5'h14, 32'h0, IER_RB, 1'b0, "ier_rd"});
        vecs.push_back('{1'b0, 5'h0C, 32'h0, 32'h0, 1'b0, "ctrl_rd"});

        foreach (vecs[i]) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, 8'h0, 1'b0, rd, err);
            chk({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
            if (!vecs[i].wr)
                chk({vecs[i].name, "_data"}, rd, vecs[i].exp_rd);
        end

        chk("cfg_out", 32'(cfg), 32'h1B);
        chk("tx_data_out", 32'(tx_data), 32'h5A);

        // start pulse: one cycle, in the cycle after the access
        wr_chk("ctrl_start", 5'h0C, 32'h1, 1'b0);
        chk("start_during_access", 32'(start_at_access), 32'h0);
        chk("start_after_access", 32'(start_tx), 32'h1);
        @(posedge pclk); #1;
        chk("start_one_cycle", 32'(start_tx), 32'h0);

        tx_busy = 1'b1;
        wr_chk("ctrl_busy", 5'h0C, 32'h1, 1'b1);
        chk("start_busy", 32'(start_tx), 32'h0);
        @(posedge pclk); #1;
        chk("start_busy_later", 32'(start_tx), 32'h0);
        wr_chk("tx_busy_wr", 5'h00, 32'h77, 1'b1);
        chk("tx_data_kept", 32'(tx_data), 32'h5A);
        rd_chk("stt_busy", 5'h10, 32'h10);
        tx_busy = 1'b0;

        // overrun: five pushes into a 4-entry FIFO
        for (int k = 0; k < 5; k++)
            pulse_rx(8'h11 + 8'(k), 1'b0);
        rd_chk("lvl_full", 5'h18, 32'h4);
        rd_chk("stt_ovr", 5'h10, 32'h0A);
        for (int k = 0; k < 4; k++)
            rd_chk("rx_pop", 5'h04, 32'h11 + 32'(k));
        rd_chk("rx_empty_pop", 5'h04, 32'h0);
        rd_chk("lvl_empty", 5'h18, 32'h0);
        rd_chk("stt_ovr_sticky", 5'h10, 32'h08);
        wr_chk("stt_clr_ovr", 5'h10, 32'h8, 1'b0);
        rd_chk("stt_ovr_cleared", 5'h10, 32'h0);

        // full FIFO with push and pop in the same cycle
        for (int k = 0; k < 4; k++)
            pulse_rx(8'h21 + 8'(k), 1'b0);
        apb(1'b0, 5'h04, 32'h0, 1'b1, 8'h25, 1'b0, rd, err);
        chk("full_pushpop_data", rd, 32'h21);
        chk("full_pushpop_err", 32'(err), 32'h0);
        rd_chk("full_pushpop_lvl", 5'h18, 32'h4);
        rd_chk("full_pushpop_stt", 5'h10, 32'h02);
        for (int k = 0; k < 4; k++)
            rd_chk("pushpop_drain", 5'h04, 32'h22 + 32'(k));
        rd_chk("pushpop_lvl_end", 5'h18, 32'h0);

        // tx_done sticky: set beats a concurrent W1C
        @(posedge pclk); #1; tx_done = 1'b1;
        @(posedge pclk); #1; tx_done = 1'b0;
        rd_chk("stt_txdone", 5'h10, 32'h01);
        apb(1'b1, 5'h10, 32'h1, 1'b0, 8'h0, 1'b1, rd, err);
        chk("w1c_race_err", 32'(err), 32'h0);
        rd_chk("stt_set_wins", 5'h10, 32'h01);
        wr_chk("stt_clr_txdone", 5'h10, 32'h1, 1'b0);
        rd_chk("stt_txdone_cleared", 5'h10, 32'h0);

        // parity error and interrupt (IER=0x4 from the table when irq is built in)
        chk("irq_idle", 32'(irq), 32'h0);
        pulse_rx(8'h3C, 1'b1);
        chk("irq_parity", 32'(irq), 32'(IRQ_ON));
        rd_chk("stt_parity", 5'h10, 32'h06);
        rd_chk("parity_char_stored", 5'h04, 32'h3C);
        chk("irq_still_set", 32'(irq), 32'(IRQ_ON));
        wr_chk("stt_clr_parity", 5'h10, 32'h4, 1'b0);
        chk("irq_cleared", 32'(irq), 32'h0);
        rd_chk("stt_final", 5'h10, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_apb_regfile.md
# uart_apb_regfile

Parametrised APB register file for the UART, the next generation of the UART register block. It sits between the APB bus and the UART TX/RX core and holds the TX data, frame configuration and control registers. It adds a RX FIFO, sticky write-1-to-clear status with overrun detection, a self-clearing start pulse, and slave-error generation, with an optional interrupt.

## Interface
- ADDR_W, 5, APB address width; registers on 4-byte word addresses
- DATA_W, 8, UART character width (5..9)
- RX_DEPTH, 4, RX FIFO entries; power of two, 2..16
- pclk  in  1  APB clock, the only clock
- preset  in  1  reset; synchronous and active-high
- psel, penable, pwrite  in  1  APB control
- paddr  in  ADDR_W  APB address
- pwdata  in  32  APB write data
- prdata  out  32  read data; registered
- pready  out  1  tied 1, no wait states
- pslverr  out  1  slave error; registered
- tx_data  out  DATA_W  character to transmit
- start_tx  out  1  one-cycle start pulse
- cfg  out  5  [1:0] data bits, [2] stop bits, [3] parity enable, [4] odd parity
- tx_busy  in  1  TX core is shifting
- tx_done  in  1  one-cycle pulse at end of a TX frame
- rx_valid  in  1  one-cycle pulse with a received character
- rx_data  in  DATA_W  received character
- rx_parity_err  in  1  qualified by rx_valid
- irq  out  1  level interrupt

## Operation
- Register map:
  - 0x00 TX_DATA, RW [DATA_W-1:0]
  - 0x04 RX_DATA, RO; pops the FIFO
  - 0x08 CFG, RW [4:0]
  - 0x0C CTRL, W [0] start; always reads 0
  - 0x10 STT: [0] tx_done, W1C sticky; [1] rx_nonempty, RO; [2] parity_err, W1C sticky; [3] rx_overrun, W1C sticky; [4] tx_busy, RO
  - 0x14 IER, RW [3:0]
  - 0x18 RX_LEVEL, RO [4:0]
- Unused bits read 0.
- Setup phase (psel & !penable):
  - Decode the address.
  - Capture prdata and the error flag.
- Access phase (psel & penable):
  - Drive the captured pslverr.
  - A write commits only when there is no error.
  - A RX_DATA read pops only if the FIFO was non-empty at setup.
- pslverr=1 on any of:
  - unmapped address
  - paddr[1:0]≠0
  - write to RX_DATA, STT bits 1/4, or RX_LEVEL (RO)
  - write to TX_DATA or CTRL while tx_busy=1
- Writing CTRL[0]=1 pulses start_tx for exactly one cycle, in the cycle after the access.
- RX FIFO:
  - Push on rx_valid.
  - Push to a full FIFO drops the character and sets rx_overrun.
  - Push and pop in the same cycle when full: no overrun, level unchanged.
  - A parity error stores the character and sets parity_err.
- Empty RX_DATA read returns 0, pslverr=0.
- Status set and W1C clear in the same cycle: set wins.
- Reset values:
  - prdata=0, pslverr=0, start_tx=0, tx_data=0, cfg=0, irq=0.
  - FIFO empty; all registers 0.

## Timing
- All state updates on the pclk rising edge.
- preset sampled synchronously; reset mid-transfer aborts the transfer and leaves nothing committed.
- Read data valid in the access cycle, one cycle after setup.
- Write effect (register, W1C clear, pop) visible from the cycle after the access phase.
- FIFO pointers wrap modulo RX_DEPTH.
- RX_LEVEL spans 0..RX_DEPTH.
- Status sets: a pulse at cycle N gives the flag readable at setup N+1.

## Configuration
- UART_REG_IRQ_EN defined:
  - IER implemented.
  - irq registered, =|(STT[3:0] & IER), with STT[1] standing for FIFO non-empty.
  - irq asserts one cycle after the cause.
- UART_REG_IRQ_EN undefined:
  - IER reads 0; writes are accepted and ignored.
  - irq is constant 0.

## Test plan
- Reset then read all seven registers -> all 0, pslverr=0; prdata=0 during and after reset.
- Write CFG=0x1B, TX_DATA=0x5A, CTRL=1 with tx_busy=0 -> cfg=0x1B, tx_data=0x5A, start_tx high exactly 1 cycle; with tx_busy=1, CTRL write -> pslverr=1, no pulse.
- RX_DEPTH=4: five rx_valid pulses 0x11..0x15 -> RX_LEVEL=4, STT[3]=1; four RX_DATA reads -> 0x11..0x14, fifth read -> 0, RX_LEVEL=0.
- FIFO full; rx_valid in the same cycle as a RX_DATA access -> no overrun, RX_LEVEL stays 4, next read returns the following entry.
- Set tx_done, write STT=0x1 in the same cycle as a new tx_done pulse -> STT[0] stays 1; a separate write -> 0.
- Write addresses 0x1C and 0x02 -> pslverr=1, no state change; with UART_REG_IRQ_EN and IER=0x4, rx_parity_err -> irq=1 next cycle, cleared by writing STT=0x4.
